pattern_scan_accel: RTL and testbench

PATTERN_SCAN_ACCEL -- requirements
Module: pattern_scan_accel

---
 rtl/user_pkg.sv | 66 ++++++
 rtl/pattern_scan_regs.sv | 132 +++++++++++++
 rtl/pattern_scan_accel.sv | 143 ++++++++++++++
 tb/tb_pattern_scan_accel.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_pkg.sv
// Shared constants and bus types for the pattern scan accelerator.
// Build option: define PATTERN_SCAN_IRQ_EN to implement CTRL.irq_en and irq_o.
package user_pkg;

  // Slot of the scan accelerator in the user address map.
  localparam int unsigned UserScan = 0;

  localparam logic [7:0] CtrlOffset      = 8'h00;
  localparam logic [7:0] StatusOffset    = 8'h04;
  localparam logic [7:0] BaseOffset      = 8'h08;
  localparam logic [7:0] LenOffset       = 8'h0C;
  localparam logic [7:0] PatternOffset   = 8'h10;
  localparam logic [7:0] MaskOffset      = 8'h14;
  localparam logic [7:0] MatchAddrOffset = 8'h18;
  localparam logic [7:0] MatchCntOffset  = 8'h1C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sbr_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mgr_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } mgr_obi_rsp_t;

  // Merge a write into an existing word, lane by lane.
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pattern_scan_regs.sv
// Register file and subordinate port of the pattern scan accelerator.
// irq_en is only implemented when PATTERN_SCAN_IRQ_EN is defined.
module pattern_scan_regs
  import user_pkg::*;
#(
  parameter int unsigned LenWidth = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  sbr_obi_req_t        sbr_req,
  output sbr_obi_rsp_t        sbr_rsp,
  input  logic                busy,
  input  logic                done,
  input  logic                match,
  input  logic                err,
  input  logic [31:0]         match_addr,
  input  logic [LenWidth-1:0] match_cnt,
  output logic                start_pulse,
  output logic                done_clr,
  output logic                err_clr,
  output logic                mode,
  output logic                irq_en,
  output logic [31:0]         base,
  output logic [LenWidth-1:0] len,
  output logic [31:0]         pattern,
  output logic [31:0]         mask
);

  logic [7:0]          offset;
  logic                wr_en;
  logic                rd_en;
  logic                ctrl_wr;
  logic                status_wr;
  logic [31:0]         len_wr;
  logic [31:0]         rd_mux;
  logic [31:0]         rdata_reg;
  logic                rvalid_reg;
  logic                mode_reg;
  logic [31:0]         base_reg;
  logic [LenWidth-1:0] len_reg;
  logic [31:0]         pattern_reg;
  logic [31:0]         mask_reg;
  logic                unused_bits;

  // Upper address bits were already decoded by the demux.
  assign offset      = {sbr_req.addr[7:2], 2'b00};
  assign wr_en       = sbr_req.req & sbr_req.we;
  assign rd_en       = sbr_req.req & ~sbr_req.we;
  assign ctrl_wr     = wr_en && (offset == CtrlOffset) && sbr_req.be[0];
  assign status_wr   = wr_en && (offset == StatusOffset) && sbr_req.be[0];
  assign len_wr      = apply_be(32'(len_reg), sbr_req.wdata, sbr_req.be);
  assign unused_bits = ^{sbr_req.addr[31:8], sbr_req.addr[1:0], len_wr[31:LenWidth]};

  assign start_pulse = ctrl_wr && sbr_req.wdata[0] && !busy;
  assign done_clr    = status_wr && sbr_req.wdata[1];
  assign err_clr     = status_wr && sbr_req.wdata[3];

  // Run configuration is frozen while a scan is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg    <= 1'b0;
      base_reg    <= '0;
      len_reg     <= '0;
      pattern_reg <= '0;
      mask_reg    <= '1;
    end else if (wr_en && !busy) begin
      case (offset)
        CtrlOffset:    if (sbr_req.be[0]) mode_reg <= sbr_req.wdata[1];
        BaseOffset:    base_reg    <= apply_be(base_reg, sbr_req.wdata, sbr_req.be);
        LenOffset:     len_reg     <= len_wr[LenWidth-1:0];
        PatternOffset: pattern_reg <= apply_be(pattern_reg, sbr_req.wdata, sbr_req.be);
        MaskOffset:    mask_reg    <= apply_be(mask_reg, sbr_req.wdata, sbr_req.be);
        default: ;
      endcase
    end
  end

`ifdef PATTERN_SCAN_IRQ_EN
  logic irq_en_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_reg <= 1'b0;
    end else if (ctrl_wr) begin
      irq_en_reg <= sbr_req.wdata[2];
    end
  end

  assign irq_en = irq_en_reg;
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (offset)
      CtrlOffset:      rd_mux = {29'd0, irq_en, mode_reg, 1'b0};
      StatusOffset:    rd_mux = {28'd0, err, match, done, busy};
      BaseOffset:      rd_mux = base_reg;
      LenOffset:       rd_mux = 32'(len_reg);
      PatternOffset:   rd_mux = pattern_reg;
      MaskOffset:      rd_mux = mask_reg;
      MatchAddrOffset: rd_mux = match_addr;
      MatchCntOffset:  rd_mux = 32'(match_cnt);
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= sbr_req.req;
      rdata_reg  <= rd_en ? rd_mux : '0;
    end
  end

  always_comb begin
    sbr_rsp        = '0;
    sbr_rsp.gnt    = sbr_req.req;
    sbr_rsp.rvalid = rvalid_reg;
    sbr_rsp.rdata  = rdata_reg;
  end

  assign mode    = mode_reg;
  assign base    = base_reg;
  assign len     = len_reg;
  assign pattern = pattern_reg;
  assign mask    = mask_reg;

endmodule

// File: rtl/pattern_scan_accel.sv
// Memory pattern scanner: reads LEN words from BASE and counts masked matches.
// Build option: define PATTERN_SCAN_IRQ_EN to enable the level interrupt irq_o.
module pattern_scan_accel
  import user_pkg::*;
#(
  parameter int unsigned LenWidth      = 16,
  parameter int unsigned BaseAddrAlign = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  sbr_obi_req_t obi_sbr_req_i,
  output sbr_obi_rsp_t obi_sbr_rsp_o,
  output mgr_obi_req_t obi_mgr_req_o,
  input  mgr_obi_rsp_t obi_mgr_rsp_i,
  output logic         irq_o
);

  localparam logic [31:0] AlignMask = ~((32'd1 << BaseAddrAlign) - 32'd1);

  scan_state_e         state_reg, state_next;
  logic [31:0]         cur_addr_reg;
  logic [LenWidth-1:0] remaining_reg;
  logic [LenWidth-1:0] match_cnt_reg;
  logic [31:0]         match_addr_reg;
  logic                match_reg;
  logic                err_reg;
  logic                done_reg;

  logic                start_pulse, done_clr, err_clr;
  logic                mode, irq_en;
  logic [31:0]         base, pattern, mask;
  logic [LenWidth-1:0] len;

  logic busy, start_accept, hit, last_beat, beat_ok, beat_err;

  pattern_scan_regs #(
    .LenWidth(LenWidth)
  ) u_regs (
    .clk        (clk_i),
    .rst        (rst_i),
    .sbr_req    (obi_sbr_req_i),
    .sbr_rsp    (obi_sbr_rsp_o),
    .busy       (busy),
    .done       (done_reg),
    .match      (match_reg),
    .err        (err_reg),
    .match_addr (match_addr_reg),
    .match_cnt  (match_cnt_reg),
    .start_pulse(start_pulse),
    .done_clr   (done_clr),
    .err_clr    (err_clr),
    .mode       (mode),
    .irq_en     (irq_en),
    .base       (base),
    .len        (len),
    .pattern    (pattern),
    .mask       (mask)
  );

  assign busy         = (state_reg == REQ) || (state_reg == WAIT);
  assign start_accept = start_pulse && (state_reg == IDLE);
  assign hit          = ((obi_mgr_rsp_i.rdata ^ pattern) & mask) == 32'd0;
  assign last_beat    = remaining_reg == LenWidth'(1);
  // Responses outside WAIT (e.g. left over from before a reset) are dropped.
  assign beat_ok      = (state_reg == WAIT) && obi_mgr_rsp_i.rvalid && !obi_mgr_rsp_i.err;
  assign beat_err     = (state_reg == WAIT) && obi_mgr_rsp_i.rvalid && obi_mgr_rsp_i.err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next       = state_reg;
    obi_mgr_req_o    = '0;
    obi_mgr_req_o.be = 4'hF;
    case (state_reg)
      IDLE: begin
        if (start_accept) state_next = (len == '0) ? DONE : REQ;
      end
      REQ: begin
        obi_mgr_req_o.req  = 1'b1;
        obi_mgr_req_o.addr = cur_addr_reg;
        if (obi_mgr_rsp_i.gnt) state_next = WAIT;
      end
      WAIT: begin
        if (beat_err) begin
          state_next = DONE;
        end else if (beat_ok) begin
          state_next = (last_beat || (hit && !mode)) ? DONE : REQ;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_addr_reg   <= '0;
      remaining_reg  <= '0;
      match_cnt_reg  <= '0;
      match_addr_reg <= '0;
      match_reg      <= 1'b0;
      err_reg        <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      if (start_accept) begin
        cur_addr_reg   <= base & AlignMask;
        remaining_reg  <= len;
        match_cnt_reg  <= '0;
        match_addr_reg <= '0;
        match_reg      <= 1'b0;
      end else if (beat_ok) begin
        cur_addr_reg  <= cur_addr_reg + 32'd4;
        remaining_reg <= remaining_reg - LenWidth'(1);
        if (hit) begin
          if (!(&match_cnt_reg)) match_cnt_reg <= match_cnt_reg + LenWidth'(1);
          if (!match_reg) begin
            match_addr_reg <= cur_addr_reg;
            match_reg      <= 1'b1;
          end
        end
      end

      // Hardware set beats a same-cycle software clear.
      if (state_reg == DONE)            done_reg <= 1'b1;
      else if (done_clr || start_accept) done_reg <= 1'b0;

      if (beat_err)                     err_reg <= 1'b1;
      else if (err_clr || start_accept) err_reg <= 1'b0;
    end
  end

`ifdef PATTERN_SCAN_IRQ_EN
  assign irq_o = done_reg & irq_en;
`else
  logic unused_irq_en;
  assign unused_irq_en = irq_en;
  assign irq_o         = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_scan_accel.sv
// Scoreboard bench for pattern_scan_accel with a stalling memory model.
module tb_pattern_scan_accel;
  import user_pkg::*;

  localparam logic [31:0] Dev = 32'h0300_0000;

  logic         clk = 1'b0;
  logic         rst;
  sbr_obi_req_t sbr_req;
  sbr_obi_rsp_t sbr_rsp;
  mgr_obi_req_t mgr_req;
  mgr_obi_rsp_t mgr_rsp;
  logic         irq;

  always #5 clk = ~clk;

  pattern_scan_accel #(
    .LenWidth     (16),
    .BaseAddrAlign(2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .obi_sbr_req_i(sbr_req),
    .obi_sbr_rsp_o(sbr_rsp),
    .obi_mgr_req_o(mgr_req),
    .obi_mgr_rsp_i(mgr_rsp),
    .irq_o        (irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  bit          chk_q[$];

  // Memory model state
  logic [31:0] mem[16];
  logic [31:0] mem_base = 32'h0;
  int          err_word = -1;
  int          gnt_delay = 0;
  int          reads = 0;
  logic        req_last = 1'b0;
  logic [31:0] addr_last = 32'h0;
  int          wait_cnt = 0;

`ifdef PATTERN_SCAN_IRQ_EN
  localparam bit IrqBuilt = 1'b1;
`else
  localparam bit IrqBuilt = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every subordinate rvalid retires the oldest pending access.
  initial begin
    logic [31:0] e;
    string       nm;
    bit          c;
    forever begin
      @(negedge clk);
      if (sbr_rsp.rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          c  = chk_q.pop_front();
          if (c) begin
            check(nm, sbr_rsp.rdata, e);
            check({nm, "_err"}, 32'(sbr_rsp.err), 32'd0);
          end
          $display("txn %-14s rdata=0x%08h", nm, sbr_rsp.rdata);
        end
      end
    end
  end

  // Memory: grant after gnt_delay stall cycles, answer one cycle after grant.
  initial begin
    bit          hs;
    logic [31:0] diff;
    mgr_rsp = '0;
    forever begin
      @(negedge clk);
      hs = mgr_rsp.gnt && req_last;
      mgr_rsp.rvalid = hs;
      mgr_rsp.err    = 1'b0;
      mgr_rsp.rdata  = 32'h0;
      if (hs) begin
        reads++;
        diff = addr_last - mem_base;
        if (diff < 32'd64) mgr_rsp.rdata = mem[diff[5:2]];
        if (diff < 32'd64 && int'(diff[5:2]) == err_word) mgr_rsp.err = 1'b1;
      end
      if (req_last && !mgr_rsp.gnt && rst === 1'b0) begin
        check("req_hold", 32'(mgr_req.req), 32'd1);
        check("addr_hold", mgr_req.addr, addr_last);
      end
      req_last  = mgr_req.req;
      addr_last = mgr_req.addr;
      if (mgr_req.req) begin
        if (wait_cnt >= gnt_delay) begin
          mgr_rsp.gnt = 1'b1;
          wait_cnt    = 0;
        end else begin
          mgr_rsp.gnt = 1'b0;
          wait_cnt++;
        end
      end else begin
        mgr_rsp.gnt = 1'b0;
        wait_cnt    = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus(input logic we, input logic [7:0] off, input logic [31:0] data,
                     input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    sbr_req.req   = 1'b1;
    sbr_req.we    = we;
    sbr_req.be    = 4'hF;
    sbr_req.addr  = Dev | 32'(off);
    sbr_req.wdata = data;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    chk_q.push_back(!we);
    @(posedge clk); #1;
    sbr_req = '0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data);
    bus(1'b1, off, data, 32'h0, "write");
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string nm);
    bus(1'b0, off, 32'h0, exp, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
  endtask

  initial begin
    rst     = 1'b1;
    sbr_req = '0;
    clear_mem();
    idle(3);
    @(negedge clk);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_mgr_req", 32'(mgr_req.req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset values, including an unmapped offset
    rd(CtrlOffset,      32'h0,        "rst_ctrl");
    rd(StatusOffset,    32'h0,        "rst_status");
    rd(BaseOffset,      32'h0,        "rst_base");
    rd(LenOffset,       32'h0,        "rst_len");
    rd(PatternOffset,   32'h0,        "rst_pattern");
    rd(MaskOffset,      32'hFFFFFFFF, "rst_mask");
    rd(MatchAddrOffset, 32'h0,        "rst_maddr");
    rd(MatchCntOffset,  32'h0,        "rst_mcnt");
    rd(8'h20,           32'h0,        "unmapped_rd");
    wr(8'h24, 32'h1234_5678);

    // Stop at first match: word 2 hits
    clear_mem(); mem[2] = 32'h0000_CAFE; mem_base = 32'h1000_0000; reads = 0;
    wr(BaseOffset, 32'h1000_0000);
    wr(LenOffset, 32'd4);
    wr(PatternOffset, 32'h0000_CAFE);
    wr(CtrlOffset, 32'h1);
    idle(40);
    check("A_reads", 32'(reads), 32'd3);
    rd(StatusOffset,    32'h6,         "A_status");
    rd(MatchAddrOffset, 32'h1000_0008, "A_maddr");
    rd(MatchCntOffset,  32'd1,         "A_mcnt");

    // Count all with mask; unaligned base is aligned on start
    clear_mem(); mem[1] = 32'hAB01_1234; mem[5] = 32'hAB01_1234; mem[7] = 32'hAB01_1234;
    mem[3] = 32'h1234_0000; mem_base = 32'h2000_0000; reads = 0;
    wr(BaseOffset, 32'h2000_0003);
    wr(LenOffset, 32'd8);
    wr(MaskOffset, 32'h0000_FFFF);
    wr(PatternOffset, 32'h0000_1234);
    wr(CtrlOffset, 32'h3);
    idle(60);
    check("B_reads", 32'(reads), 32'd8);
    rd(StatusOffset,    32'h6,         "B_status");
    rd(MatchCntOffset,  32'd3,         "B_mcnt");
    rd(MatchAddrOffset, 32'h2000_0004, "B_maddr");
    rd(BaseOffset,      32'h2000_0003, "B_base");
    rd(CtrlOffset,      32'h2,         "B_ctrl");
    wr(StatusOffset, 32'h2);
    rd(StatusOffset,    32'h4,         "B_w1c_done");

    // Zero length: done without any memory traffic
    reads = 0;
    wr(LenOffset, 32'd0);
    wr(CtrlOffset, 32'h1);
    rd(StatusOffset,    32'h2,         "C_status");
    idle(10);
    check("C_reads", 32'(reads), 32'd0);
    rd(MatchCntOffset,  32'd0,         "C_mcnt");

    // Bus error on word 1 of 4
    clear_mem(); err_word = 1; mem_base = 32'h2000_0000; reads = 0;
    wr(MaskOffset, 32'hFFFF_FFFF);
    wr(PatternOffset, 32'h0000_5555);
    wr(LenOffset, 32'd4);
    wr(CtrlOffset, 32'h3);
    idle(40);
    check("D_reads", 32'(reads), 32'd2);
    rd(StatusOffset,    32'hA,         "D_status");
    rd(MatchCntOffset,  32'd0,         "D_mcnt");
    wr(StatusOffset, 32'h8);
    rd(StatusOffset,    32'h2,         "D_w1c_err");
    err_word = -1;

    // Grant stalled 5 cycles; config writes while busy are dropped
    clear_mem(); mem[2] = 32'h77; mem_base = 32'h3000_0000; gnt_delay = 5; reads = 0;
    wr(BaseOffset, 32'h3000_0000);
    wr(LenOffset, 32'd3);
    wr(PatternOffset, 32'h77);
    wr(CtrlOffset, 32'h1);
    wr(PatternOffset, 32'h99);
    wr(MaskOffset, 32'h0);
    rd(StatusOffset,    32'h1,         "E_busy");
    idle(80);
    check("E_reads", 32'(reads), 32'd3);
    rd(PatternOffset,   32'h77,        "E_pattern");
    rd(MaskOffset,      32'hFFFF_FFFF, "E_mask");
    rd(StatusOffset,    32'h6,         "E_status");
    rd(MatchAddrOffset, 32'h3000_0008, "E_maddr");
    gnt_delay = 0;

    // Reset in the middle of a run with irq_en set
    clear_mem(); mem_base = 32'h1000_0000;
    wr(LenOffset, 32'd8);
    wr(PatternOffset, 32'hDEAD);
    wr(CtrlOffset, 32'h5);
    idle(5);
    @(posedge clk); #3;
    rst = 1'b1;
    @(negedge clk);
    check("F_rst_irq", 32'(irq), 32'd0);
    check("F_rst_rvalid", 32'(sbr_rsp.rvalid), 32'd0);
    check("F_rst_mgr_req", 32'(mgr_req.req), 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    idle(5);
    rd(StatusOffset,    32'h0,         "F_status");
    rd(CtrlOffset,      32'h0,         "F_ctrl");
    rd(MatchCntOffset,  32'h0,         "F_mcnt");
    rd(MaskOffset,      32'hFFFF_FFFF, "F_mask");
    clear_mem(); mem[2] = 32'h0000_CAFE; reads = 0;
    wr(BaseOffset, 32'h1000_0000);
    wr(LenOffset, 32'd4);
    wr(PatternOffset, 32'h0000_CAFE);
    wr(CtrlOffset, 32'h5);
    idle(40);
    check("F_reads", 32'(reads), 32'd3);
    rd(StatusOffset,    32'h6,         "F_status2");
    rd(MatchAddrOffset, 32'h1000_0008, "F_maddr");
    rd(CtrlOffset,      IrqBuilt ? 32'h4 : 32'h0, "F_ctrl2");
    @(negedge clk);
    check("F_irq_done", 32'(irq), IrqBuilt ? 32'd1 : 32'd0);
    wr(StatusOffset, 32'h2);
    @(negedge clk);
    check("F_irq_clr", 32'(irq), 32'd0);

    // Address wraps past 0xFFFF_FFFC
    clear_mem(); mem[3] = 32'hBEEF; mem_base = 32'hFFFF_FFF8; reads = 0;
    wr(BaseOffset, 32'hFFFF_FFF8);
    wr(LenOffset, 32'd4);
    wr(PatternOffset, 32'hBEEF);
    wr(CtrlOffset, 32'h3);
    idle(40);
    check("G_reads", 32'(reads), 32'd4);
    rd(MatchAddrOffset, 32'h0000_0004, "G_maddr");
    rd(MatchCntOffset,  32'd1,         "G_mcnt");
    rd(StatusOffset,    32'h6,         "G_status");

    idle(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
